// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared FSM states, next-PC select encodings and instruction field positions.
package instr_fetch_pkg;
  typedef enum logic [1:0] {FETCH, ISSUE, HALT} state_e;
  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JMP  = 2'b10;
  localparam logic [1:0] PC_HALT = 2'b11;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  localparam int TGT_MSB = 25;
  localparam int TGT_LSB = 0;
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction
endpackage

// File: rtl/instr_fetch_pc_next.sv
// pc_next: combinational next-PC selection for sequential, branch, jump and halt.
module pc_next
  import instr_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [1:0]  pc_cnt,
  input  logic        branch_taken,
  output logic [31:0] next_pc
);
  logic [31:0] pc_plus4;
  logic        unused_opc;
  assign pc_plus4   = pc + 32'd4;
  assign unused_opc = ^instr[OPC_MSB:OPC_LSB];
  // Jump target keeps the 256 MB region of the following instruction.
  always_comb
    next_pc = pc_cnt == PC_JMP ? {pc_plus4[31:28], instr[TGT_MSB:TGT_LSB], 2'b00} :
              pc_cnt == PC_HALT ? pc :
              (pc_cnt == PC_BR && branch_taken) ? pc_plus4 + br_offset(instr[IMM_MSB:IMM_LSB]) :
              pc_plus4;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch/issue FSM holding pc and the instruction under issue.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        issue_ready,
  input  logic [1:0]  pc_cnt,
  input  logic        branch_taken,
  output logic [31:0] pc
);
  state_e      state_q;
  logic [31:0] pc_q, instr_q, pc_d;
  logic        req_q, valid_q;
  pc_next u_pc_next (
    .pc          (pc_q),
    .instr       (instr_q),
    .pc_cnt      (pc_cnt),
    .branch_taken(branch_taken),
    .next_pc     (pc_d)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: if (imem_ack) begin
          instr_q <= imem_rdata;
          state_q <= ISSUE;
          req_q   <= 1'b0;
          valid_q <= 1'b1;
        end
        ISSUE: if (issue_ready) begin
          valid_q <= 1'b0;
          if (pc_cnt == PC_HALT) state_q <= HALT;
          else begin
            pc_q    <= pc_d;
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end
        default: state_q <= HALT;
      endcase
    end
  end
  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[OPC_MSB:OPC_LSB];
  assign instr_valid = valid_q;
endmodule
